// File: rtl/mux_arb.sv
// Two-requester arbiter with hold limit and a one-cycle GAP between grants,
// driving a registered 2:1 mux. State is exported on the state port.
module mux_arb #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned W        = 8
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         sel,
  output logic         busy,
  output logic [3:0]   hold_cnt,
  output logic [W-1:0] out,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_t         state_q, state_d;
  logic           lw_q, lw_d;
  logic           sel_q, sel_d;
  logic [3:0]     hold_q, hold_d;
  logic           gnt0_q, gnt1_q;
  logic [W-1:0]   out_q;

  // Handshake: reqx is a level; while held high it keeps its grant until
  // the hold limit is reached with the other side waiting. gntx is the
  // registered acknowledge, never high on both sides at once.
  always_comb begin
    state_d = state_q;
    lw_d    = lw_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE, GAP: begin
        state_d = IDLE;
        hold_d  = 4'd0;
        // With both requesting, the side that did not win last goes first.
        if (req0 && (!req1 || lw_q)) begin
          state_d = GNT0;
          sel_d   = 1'b0;
          hold_d  = 4'd1;
        end else if (req1) begin
          state_d = GNT1;
          sel_d   = 1'b1;
          hold_d  = 4'd1;
        end
      end
      GNT0: begin
        if (!req0 || (hold_q == MAX_HOLD_C && req1)) begin
          lw_d    = 1'b0;
          hold_d  = 4'd0;
          state_d = req1 ? GAP : IDLE;
        end else if (hold_q != MAX_HOLD_C) begin
          hold_d = hold_q + 4'd1;
        end
      end
      GNT1: begin
        if (!req1 || (hold_q == MAX_HOLD_C && req0)) begin
          lw_d    = 1'b1;
          hold_d  = 4'd0;
          state_d = req0 ? GAP : IDLE;
        end else if (hold_q != MAX_HOLD_C) begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      lw_q    <= 1'b1;
      sel_q   <= 1'b0;
      hold_q  <= 4'd0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      lw_q    <= lw_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      gnt0_q  <= (state_d == GNT0);
      gnt1_q  <= (state_d == GNT1);
      out_q   <= sel_q ? in1 : in0;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign sel      = sel_q;
  assign hold_cnt = hold_q;
  assign out      = out_q;
  assign busy     = (state_q != IDLE);
  assign state    = state_q;

endmodule

// File: tb/tb_mux_arb.sv
// Directed bench for mux_arb: reset values, grant latency, hold limit,
// saturation, alternation through GAP, async reset mid-grant, mux output.
module tb_mux_arb;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic [W-1:0] in0 = 8'hA5;
  logic [W-1:0] in1 = 8'h5A;
  logic         gnt0, gnt1, sel, busy;
  logic [3:0]   hold_cnt;
  logic [W-1:0] out;
  logic [1:0]   state;

  int n_tests = 0;
  int n_fail  = 0;

  mux_arb #(.MAX_HOLD(8), .W(W)) dut (
    .clk(clk), .nreset(nreset), .req0(req0), .req1(req1),
    .in0(in0), .in1(in1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .busy(busy),
    .hold_cnt(hold_cnt), .out(out), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_arb(input string tag, input logic e_g0, input logic e_g1,
                         input logic e_sel, input logic e_busy, input logic [3:0] e_hold);
    chk({tag, " gnt0"}, {7'd0, gnt0}, {7'd0, e_g0});
    chk({tag, " gnt1"}, {7'd0, gnt1}, {7'd0, e_g1});
    chk({tag, " sel"},  {7'd0, sel},  {7'd0, e_sel});
    chk({tag, " busy"}, {7'd0, busy}, {7'd0, e_busy});
    chk({tag, " hold"}, {4'd0, hold_cnt}, {4'd0, e_hold});
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    req0   = 1'b0;
    req1   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
  endtask

  initial begin
    // Reset values
    do_reset();
    chk_arb("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("reset out", out, 8'h00);
    chk("reset state", {6'd0, state}, 8'd0);

    // Single request: one-cycle latency, release back to IDLE
    req0 = 1'b1;
    tick();
    chk_arb("req0 grant", 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
    req0 = 1'b0;
    tick();
    chk_arb("req0 release", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Both requesting: GNT0 first, alternating 8-cycle grants with GAPs
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 1; i <= 8; i++) begin
        tick();
        if (ph % 2 == 0) chk_arb($sformatf("alt p%0d c%0d", ph, i), 1'b1, 1'b0, 1'b0, 1'b1, 4'(i));
        else             chk_arb($sformatf("alt p%0d c%0d", ph, i), 1'b0, 1'b1, 1'b1, 1'b1, 4'(i));
        if (i == 1 && ph > 0)
          chk($sformatf("alt p%0d out lag", ph), out, (ph % 2 == 0) ? in1 : in0);
        if (i >= 2)
          chk($sformatf("alt p%0d c%0d out", ph, i), out, (ph % 2 == 0) ? in0 : in1);
      end
      tick();
      chk_arb($sformatf("alt p%0d gap", ph), 1'b0, 1'b0, (ph % 2 == 0) ? 1'b0 : 1'b1, 1'b1, 4'd0);
      chk($sformatf("alt p%0d gap state", ph), {6'd0, state}, 8'd3);
    end

    // Lone req1 for 20 cycles: hold saturates at 8, no wrap
    do_reset();
    req1 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk_arb($sformatf("sat c%0d", i), 1'b0, 1'b1, 1'b1, 1'b1, (i > 8) ? 4'd8 : 4'(i));
    end
    // Competitor arrives after saturation: exit next edge via GAP
    req0 = 1'b1;
    tick();
    chk_arb("sat preempt gap", 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    tick();
    chk_arb("sat preempt gnt0", 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);

    // Owner drops while other waits: GAP then other side
    req0 = 1'b0;
    tick();
    chk_arb("drop gap", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    chk_arb("drop gnt1", 1'b0, 1'b1, 1'b1, 1'b1, 4'd1);

    // Both drop together mid-grant: straight to IDLE
    req1 = 1'b0;
    tick();
    chk_arb("both drop", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("both drop state", {6'd0, state}, 8'd0);

    // Async reset during GNT1 at hold 3, then GNT0 wins first after release
    do_reset();
    req1 = 1'b1;
    repeat (3) tick();
    chk_arb("pre-rst gnt1", 1'b0, 1'b1, 1'b1, 1'b1, 4'd3);
    nreset = 1'b0;
    req0   = 1'b1;
    #1;
    chk_arb("async rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("async rst out", out, 8'h00);
    tick();
    nreset = 1'b1;
    tick();
    chk_arb("post-rst gnt0", 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
